regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass_pkg.sv | 8 +
 rtl/regfile_bypass_if.sv | 33 +++
 rtl/regfile_bypass_rport.sv | 32 +++
 rtl/regfile_bypass.sv | 50 +++++
 tb/tb_regfile_bypass.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/regfile_bypass_pkg.sv
// regfile_bypass_pkg: shared widths, zero-register address and counter limit
package regfile_bypass_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD = 2;
  localparam int ZERO_REG = 0;
  localparam logic [31:0] WR_COUNT_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/regfile_bypass_if.sv
// regfile_bypass_if: read ports, pipeline write stages and hazard/status bundle
interface regfile_bypass_if import regfile_bypass_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD = DEF_NREAD
);
  logic [NREAD-1:0] re;
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic ex_we;
  logic [ADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_wdata;
  logic ex_is_load;
  logic mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic stall_req;
  logic [NREAD-1:0] hazard_port;
  logic [31:0] wr_count;
  modport master (
    output re, raddr, ex_we, ex_waddr, ex_wdata, ex_is_load,
           mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
    input rdata, stall_req, hazard_port, wr_count
  );
  modport slave (
    input re, raddr, ex_we, ex_waddr, ex_wdata, ex_is_load,
          mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
    output rdata, stall_req, hazard_port, wr_count
  );
endinterface

// File: rtl/regfile_bypass_rport.sv
// regfile_bypass_rport: one read port's forwarding mux and load-use detect
module regfile_bypass_rport import regfile_bypass_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic re,
  input logic [ADDR_W-1:0] raddr,
  input logic [DATA_W-1:0] stored,
  input logic ex_we,
  input logic [ADDR_W-1:0] ex_waddr,
  input logic [DATA_W-1:0] ex_wdata,
  input logic ex_is_load,
  input logic mem_we,
  input logic [ADDR_W-1:0] mem_waddr,
  input logic [DATA_W-1:0] mem_wdata,
  input logic wb_we,
  input logic [ADDR_W-1:0] wb_waddr,
  input logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic hazard
);
  logic is_zero, ex_hit, mem_hit, wb_hit;
  always_comb begin
    is_zero = raddr == ADDR_W'(ZERO_REG);
    ex_hit = ex_we && ex_waddr == raddr;
    mem_hit = mem_we && mem_waddr == raddr;
    wb_hit = wb_we && wb_waddr == raddr;
    // youngest stage wins; WB hit gives same-cycle write-through
    rdata = is_zero ? '0 : ex_hit ? ex_wdata : mem_hit ? mem_wdata : wb_hit ? wb_wdata : stored;
    hazard = re && !is_zero && ex_hit && ex_is_load;
  end
endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: register file with EX/MEM/WB forwarding and load-use stall
module regfile_bypass import regfile_bypass_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD = DEF_NREAD
) (
  input logic clk,
  input logic resetn,
  regfile_bypass_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [31:0] wr_count;
  logic [NREAD-1:0] hazard;
  logic [NREAD*DATA_W-1:0] rdata;
  logic commit;
  assign commit = bus.wb_we && bus.wb_waddr != ADDR_W'(ZERO_REG);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[bus.wb_waddr] <= bus.wb_wdata;
      wr_count <= wr_count == WR_COUNT_MAX ? wr_count : wr_count + 32'd1;
    end
  end
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    regfile_bypass_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport (
      .re(bus.re[p]),
      .raddr(bus.raddr[p*ADDR_W +: ADDR_W]),
      .stored(regs[bus.raddr[p*ADDR_W +: ADDR_W]]),
      .ex_we(bus.ex_we),
      .ex_waddr(bus.ex_waddr),
      .ex_wdata(bus.ex_wdata),
      .ex_is_load(bus.ex_is_load),
      .mem_we(bus.mem_we),
      .mem_waddr(bus.mem_waddr),
      .mem_wdata(bus.mem_wdata),
      .wb_we(bus.wb_we),
      .wb_waddr(bus.wb_waddr),
      .wb_wdata(bus.wb_wdata),
      .rdata(rdata[p*DATA_W +: DATA_W]),
      .hazard(hazard[p])
    );
  end
  assign bus.rdata = rdata;
  assign bus.hazard_port = hazard;
  assign bus.stall_req = |hazard;
  assign bus.wr_count = wr_count;
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: directed checks of forwarding, hazards, zero reg and reset
module tb_regfile_bypass;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  regfile_bypass_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus ();
  regfile_bypass_if #(.DATA_W(64), .ADDR_W(5), .NREAD(4)) bus4 ();
  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  regfile_bypass #(.DATA_W(64), .ADDR_W(5), .NREAD(4)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.re = '0; bus.raddr = '0;
    bus.ex_we = 0; bus.ex_waddr = '0; bus.ex_wdata = '0; bus.ex_is_load = 0;
    bus.mem_we = 0; bus.mem_waddr = '0; bus.mem_wdata = '0;
    bus.wb_we = 0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus4.re = '0; bus4.raddr = '0;
    bus4.ex_we = 0; bus4.ex_waddr = '0; bus4.ex_wdata = '0; bus4.ex_is_load = 0;
    bus4.mem_we = 0; bus4.mem_waddr = '0; bus4.mem_wdata = '0;
    bus4.wb_we = 0; bus4.wb_waddr = '0; bus4.wb_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    bus.raddr = {5'd6, 5'd5};
    #1;
    total++; if (bus.wr_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=%h", bus.wr_count, 32'd0); end
    total++; if (bus.rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 64'd0); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
  endtask

  task automatic test_write_read();
    bus.raddr = {5'd0, 5'd5};
    bus.wb_we = 1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'h1234_5678;
    #1;
    total++; if (bus.rdata[31:0] !== 32'h1234_5678) begin bad++; $display("FAIL wb_through got=%h exp=%h", bus.rdata[31:0], 32'h1234_5678); end
    tick();
    bus.wb_we = 0; bus.wb_wdata = '0;
    bus.raddr = {5'd5, 5'd5};
    #1;
    total++; if (bus.rdata !== {32'h1234_5678, 32'h1234_5678}) begin bad++; $display("FAIL r5_stored got=%h exp=%h", bus.rdata, {32'h1234_5678, 32'h1234_5678}); end
    total++; if (bus.wr_count !== 32'd1) begin bad++; $display("FAIL count_1 got=%0d exp=1", bus.wr_count); end
  endtask

  task automatic test_priority();
    bus.raddr = {5'd5, 5'd7};
    bus.ex_we = 1; bus.ex_waddr = 5'd7; bus.ex_wdata = 32'hA;
    bus.mem_we = 1; bus.mem_waddr = 5'd7; bus.mem_wdata = 32'hB;
    bus.wb_we = 1; bus.wb_waddr = 5'd7; bus.wb_wdata = 32'hC;
    #1;
    total++; if (bus.rdata[31:0] !== 32'hA) begin bad++; $display("FAIL prio_ex got=%h exp=%h", bus.rdata[31:0], 32'hA); end
    total++; if (bus.rdata[63:32] !== 32'h1234_5678) begin bad++; $display("FAIL prio_other got=%h exp=%h", bus.rdata[63:32], 32'h1234_5678); end
    bus.ex_we = 0;
    #1;
    total++; if (bus.rdata[31:0] !== 32'hB) begin bad++; $display("FAIL prio_mem got=%h exp=%h", bus.rdata[31:0], 32'hB); end
    bus.mem_we = 0;
    #1;
    total++; if (bus.rdata[31:0] !== 32'hC) begin bad++; $display("FAIL prio_wb got=%h exp=%h", bus.rdata[31:0], 32'hC); end
    tick();
    bus.wb_we = 0; bus.wb_wdata = '0;
    #1;
    total++; if (bus.rdata[31:0] !== 32'hC) begin bad++; $display("FAIL r7_stored got=%h exp=%h", bus.rdata[31:0], 32'hC); end
    total++; if (bus.wr_count !== 32'd2) begin bad++; $display("FAIL count_2 got=%0d exp=2", bus.wr_count); end
  endtask

  task automatic test_hazard();
    bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_waddr = 5'd3; bus.ex_wdata = 32'h33;
    bus.re = 2'b10; bus.raddr = {5'd3, 5'd4};
    #1;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL hz_stall got=%b exp=1", bus.stall_req); end
    total++; if (bus.hazard_port !== 2'b10) begin bad++; $display("FAIL hz_port got=%b exp=10", bus.hazard_port); end
    bus.re = 2'b00;
    #1;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL hz_re_off got=%b exp=0", bus.stall_req); end
    total++; if (bus.rdata[63:32] !== 32'h33) begin bad++; $display("FAIL re_indep got=%h exp=%h", bus.rdata[63:32], 32'h33); end
    bus.re = 2'b11; bus.raddr = {5'd4, 5'd3};
    #1;
    total++; if (bus.hazard_port !== 2'b01) begin bad++; $display("FAIL hz_port0 got=%b exp=01", bus.hazard_port); end
    bus.ex_is_load = 0;
    #1;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL hz_not_load got=%b exp=0", bus.stall_req); end
    bus.ex_we = 0; bus.ex_is_load = 1;
    #1;
    total++; if (bus.hazard_port !== 2'b00) begin bad++; $display("FAIL hz_no_we got=%b exp=00", bus.hazard_port); end
    idle();
  endtask

  task automatic test_zero();
    bus.raddr = {5'd0, 5'd0};
    bus.wb_we = 1; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'hFFFF_FFFF;
    #1;
    total++; if (bus.rdata[31:0] !== 32'd0) begin bad++; $display("FAIL r0_through got=%h exp=0", bus.rdata[31:0]); end
    tick();
    bus.wb_we = 0;
    #1;
    total++; if (bus.rdata !== 64'd0) begin bad++; $display("FAIL r0_stored got=%h exp=0", bus.rdata); end
    total++; if (bus.wr_count !== 32'd2) begin bad++; $display("FAIL r0_count got=%0d exp=2", bus.wr_count); end
    bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_waddr = 5'd0; bus.ex_wdata = 32'h77; bus.re = 2'b11;
    #1;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", bus.stall_req); end
    total++; if (bus.rdata[31:0] !== 32'd0) begin bad++; $display("FAIL r0_ex_fwd got=%h exp=0", bus.rdata[31:0]); end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.wb_we = 1; bus.wb_waddr = 5'd9; bus.wb_wdata = 32'h55;
    tick();
    bus.wb_we = 0;
    bus.raddr = {5'd5, 5'd9};
    #1;
    total++; if (bus.rdata[31:0] !== 32'h55) begin bad++; $display("FAIL r9_stored got=%h exp=%h", bus.rdata[31:0], 32'h55); end
    total++; if (bus.wr_count !== 32'd3) begin bad++; $display("FAIL count_3 got=%0d exp=3", bus.wr_count); end
    resetn = 0;
    bus.wb_we = 1; bus.wb_wdata = 32'h66;
    #1;
    total++; if (bus.rdata[31:0] !== 32'h66) begin bad++; $display("FAIL rst_fwd got=%h exp=%h", bus.rdata[31:0], 32'h66); end
    tick();
    resetn = 1;
    bus.wb_we = 0;
    #1;
    total++; if (bus.rdata !== 64'd0) begin bad++; $display("FAIL rst_clear got=%h exp=0", bus.rdata); end
    total++; if (bus.wr_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.wr_count); end
    bus.wb_we = 1; bus.wb_waddr = 5'd2; bus.wb_wdata = 32'h22;
    tick();
    bus.wb_we = 0; bus.raddr = {5'd0, 5'd2};
    #1;
    total++; if (bus.rdata[31:0] !== 32'h22) begin bad++; $display("FAIL resume_data got=%h exp=%h", bus.rdata[31:0], 32'h22); end
    total++; if (bus.wr_count !== 32'd1) begin bad++; $display("FAIL resume_count got=%0d exp=1", bus.wr_count); end
    idle();
  endtask

  task automatic test_wide();
    bus4.wb_we = 1; bus4.wb_waddr = 5'd1; bus4.wb_wdata = 64'h1111_2222_3333_4444;
    tick();
    bus4.wb_waddr = 5'd2; bus4.wb_wdata = 64'h5555_6666_7777_8888;
    tick();
    bus4.wb_waddr = 5'd3; bus4.wb_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    bus4.raddr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    total++; if (bus4.rdata[63:0] !== 64'h1111_2222_3333_4444) begin bad++; $display("FAIL w_p0 got=%h exp=%h", bus4.rdata[63:0], 64'h1111_2222_3333_4444); end
    total++; if (bus4.rdata[127:64] !== 64'h5555_6666_7777_8888) begin bad++; $display("FAIL w_p1 got=%h exp=%h", bus4.rdata[127:64], 64'h5555_6666_7777_8888); end
    total++; if (bus4.rdata[191:128] !== 64'hDEAD_BEEF_0BAD_F00D) begin bad++; $display("FAIL w_p2 got=%h exp=%h", bus4.rdata[191:128], 64'hDEAD_BEEF_0BAD_F00D); end
    total++; if (bus4.rdata[255:192] !== 64'd0) begin bad++; $display("FAIL w_p3 got=%h exp=0", bus4.rdata[255:192]); end
    tick();
    bus4.wb_we = 0;
    #1;
    total++; if (bus4.rdata[191:128] !== 64'hDEAD_BEEF_0BAD_F00D) begin bad++; $display("FAIL w_p2_stored got=%h exp=%h", bus4.rdata[191:128], 64'hDEAD_BEEF_0BAD_F00D); end
    total++; if (bus4.wr_count !== 32'd3) begin bad++; $display("FAIL w_count got=%0d exp=3", bus4.wr_count); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_hazard();
    test_zero();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
